// File: rtl/pixel_stream_if.sv
// pixel_stream_if
//   Bundles the receiver's stream input, readback request and display
//   outputs. The rasterizer/testbench side uses the master modport and
//   pixel_stream_receiver uses the slave modport.
//
//   frame_sync   master->slave  one-cycle frame start marker
//   pixel_data   master->slave  serialized pixel (bit 0 only)
//   rd_y         master->slave  readback row index
//   rd_row       slave->master  registered front-buffer row rd_y
//   row_sel      slave->master  one-hot active scan row
//   col_data     slave->master  column pixels of the active scan row
//   frame_done   slave->master  pulse: frame committed
//   frame_abort  slave->master  pulse: capture cut short by new frame_sync
//   frame_count  slave->master  committed frames, mod 256
interface pixel_stream_if;
    logic       frame_sync;
    logic [3:0] pixel_data;
    logic [2:0] rd_y;
    logic [7:0] rd_row;
    logic [7:0] row_sel;
    logic [7:0] col_data;
    logic       frame_done;
    logic       frame_abort;
    logic [7:0] frame_count;

    modport master (
        output frame_sync, pixel_data, rd_y,
        input  rd_row, row_sel, col_data, frame_done, frame_abort, frame_count
    );

    modport slave (
        input  frame_sync, pixel_data, rd_y,
        output rd_row, row_sel, col_data, frame_done, frame_abort, frame_count
    );
endinterface

// File: rtl/pixel_stream_receiver.sv
// pixel_stream_receiver
//   Captures a 64-pixel serialized frame after frame_sync into a back buffer,
//   swaps it to the front atomically on completion, and serves the front
//   buffer to an 8x8 row scanner and a registered readback port.
//
//   Parameters:
//     FIRST_OFFSET  cycles from the frame_sync cycle to sample 0 (1..4)
//     REFRESH_DIV   cycles each scan row is held (2..256)
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    pixel_stream_if.slave (stream in, readback, scan outputs)
module pixel_stream_receiver #(
    parameter int FIRST_OFFSET = 1,
    parameter int REFRESH_DIV  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    pixel_stream_if.slave  bus
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    // Last SKIP count value; only meaningful when FIRST_OFFSET > 1.
    localparam logic [1:0] SKIP_LAST = 2'(FIRST_OFFSET - 2);

    typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, COMMIT} state_t;

    // A frame start (from IDLE, COMMIT or an abort) always lands here.
    localparam state_t START_ST = (FIRST_OFFSET > 1) ? SKIP : CAPTURE;

    state_t      state, state_nxt;
    logic [1:0]  skip_cnt;
    logic [5:0]  smp_cnt;
    logic [63:0] buf0, buf1;
    logic        sel;
    logic [63:0] front;
    logic        start, wr_en, commit, abort;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]  row;
    logic [2:0]  row_nxt;
    logic        unused_pix;

    assign unused_pix = ^bus.pixel_data[3:1];

    // sel picks which physical buffer is the front; the other is the back.
    assign front   = sel ? buf1 : buf0;
    assign row_nxt = row + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        wr_en     = 1'b0;
        commit    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.frame_sync) begin
                    start     = 1'b1;
                    state_nxt = START_ST;
                end
            end
            SKIP: begin
                if (bus.frame_sync) begin
                    abort     = 1'b1;
                    start     = 1'b1;
                    state_nxt = START_ST;
                end else if (skip_cnt == SKIP_LAST) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                // A sync on any capture cycle, including the last sample,
                // restarts; the cut-short frame is never committed.
                if (bus.frame_sync) begin
                    abort     = 1'b1;
                    start     = 1'b1;
                    state_nxt = START_ST;
                end else begin
                    wr_en = 1'b1;
                    if (smp_cnt == 6'd63) state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                commit = 1'b1;
                if (bus.frame_sync) begin
                    start     = 1'b1;
                    state_nxt = START_ST;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_cnt <= '0;
            smp_cnt  <= '0;
        end else if (start) begin
            skip_cnt <= '0;
            smp_cnt  <= '0;
        end else begin
            if (state == SKIP) skip_cnt <= skip_cnt + 2'd1;
            if (wr_en)         smp_cnt  <= smp_cnt + 6'd1;
        end
    end

    // Sample k lands at bit k: row k[5:3], column k[2:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf0 <= '0;
            buf1 <= '0;
        end else if (wr_en) begin
            if (sel) buf0[smp_cnt] <= bus.pixel_data[0];
            else     buf1[smp_cnt] <= bus.pixel_data[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel             <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.frame_abort <= 1'b0;
            bus.frame_count <= '0;
        end else begin
            bus.frame_done  <= commit;
            bus.frame_abort <= abort;
            if (commit) begin
                sel             <= ~sel;
                bus.frame_count <= bus.frame_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.rd_row <= '0;
        else        bus.rd_row <= front[{bus.rd_y, 3'b000} +: 8];
    end

    // Scanner: col_data is only reloaded at a row boundary, so a commit in
    // mid-row shows up at the next boundary and a row is never torn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt      <= '0;
            row          <= '0;
            bus.row_sel  <= 8'h01;
            bus.col_data <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt      <= '0;
            row          <= row_nxt;
            bus.row_sel  <= 8'h01 << row_nxt;
            bus.col_data <= front[{row_nxt, 3'b000} +: 8];
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_stream_receiver.sv
// tb_pixel_stream_receiver
//   Drives two receivers (FIRST_OFFSET=1/REFRESH_DIV=4 and
//   FIRST_OFFSET=3/REFRESH_DIV=16) with the same stream and compares every
//   output each cycle against a frame-level reference model, plus directed
//   sequences with hand-derived constants.
module tb_pixel_stream_receiver;

    localparam int F0 = 1, RD0 = 4;
    localparam int F1 = 3, RD1 = 16;

    typedef struct packed {
        logic [7:0] rd;
        logic [7:0] rs;
        logic [7:0] col;
        logic [7:0] cnt;
        logic       done;
        logic       ab;
    } obs_t;

    typedef struct {
        logic [2:0] rd_y;
        logic [7:0] exp_row;
    } rb_vec_t;

    typedef struct {
        int         cyc;
        logic [7:0] exp_sel;
    } sc_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pixel_stream_if bus0();
    pixel_stream_if bus1();

    pixel_stream_receiver #(.FIRST_OFFSET(F0), .REFRESH_DIV(RD0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    pixel_stream_receiver #(.FIRST_OFFSET(F1), .REFRESH_DIV(RD1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    obs_t obs [2];
    assign obs[0] = {bus0.rd_row, bus0.row_sel, bus0.col_data, bus0.frame_count,
                     bus0.frame_done, bus0.frame_abort};
    assign obs[1] = {bus1.rd_row, bus1.row_sel, bus1.col_data, bus1.frame_count,
                     bus1.frame_done, bus1.frame_abort};

    // Reference model state: cycle index since reset, open frame per DUT.
    int          t;
    bit          m_act   [2];
    int          m_s     [2];
    logic [63:0] m_cap   [2];
    logic [63:0] m_front [2];
    obs_t        m_exp   [2];

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt [2];
    int abort_cnt [2];
    int dq [$];

    rb_vec_t rb_tab [8];
    sc_vec_t sc_tab [40];

    function automatic int foff(input int i);
        return (i == 0) ? F0 : F1;
    endfunction

    function automatic int rdiv(input int i);
        return (i == 0) ? RD0 : RD1;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, i, t, act, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < 2; i++) begin
            m_act[i]   = 1'b0;
            m_s[i]     = 0;
            m_cap[i]   = '0;
            m_front[i] = '0;
            m_exp[i]   = {8'h00, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0};
        end
    endtask

    // Expected outputs for cycle t+1 given inputs in cycle t:
    // sample k of a frame started at S is the pixel of cycle S+F+k, the
    // commit cycle is S+F+64, and any sync before that restarts the frame.
    task automatic model_step(input logic s, input logic p, input logic [2:0] ry);
        for (int i = 0; i < 2; i++) begin
            int f, rd, k, r;
            logic [63:0] fr;
            obs_t e;
            f  = foff(i);
            rd = rdiv(i);
            fr = m_front[i];
            e  = m_exp[i];
            e.done = 1'b0;
            e.ab   = 1'b0;
            e.rd   = fr[int'(ry)*8 +: 8];
            if ((t + 1) % rd == 0) begin
                r     = ((t + 1) / rd) % 8;
                e.rs  = 8'(1 << r);
                e.col = fr[r*8 +: 8];
            end
            if (m_act[i]) begin
                k = t - m_s[i] - f;
                if (k >= 0 && k < 64) m_cap[i][k] = p;
                if (k == 64) begin
                    m_front[i] = m_cap[i];
                    e.cnt      = e.cnt + 8'd1;
                    e.done     = 1'b1;
                    m_act[i]   = 1'b0;
                end else if (s) begin
                    e.ab = 1'b1;
                end
            end
            if (s) begin
                m_act[i] = 1'b1;
                m_s[i]   = t;
            end
            m_exp[i] = e;
        end
        t++;
    endtask

    task automatic step(input logic s, input logic p, input logic [2:0] ry);
        logic [3:0] pd;
        pd = {3'($urandom_range(0, 7)), p};
        bus0.frame_sync = s;  bus1.frame_sync = s;
        bus0.pixel_data = pd; bus1.pixel_data = pd;
        bus0.rd_y = ry;       bus1.rd_y = ry;
        model_step(s, p, ry);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rd_row",      i, 32'(obs[i].rd),   32'(m_exp[i].rd));
            chk("row_sel",     i, 32'(obs[i].rs),   32'(m_exp[i].rs));
            chk("col_data",    i, 32'(obs[i].col),  32'(m_exp[i].col));
            chk("frame_count", i, 32'(obs[i].cnt),  32'(m_exp[i].cnt));
            chk("frame_done",  i, 32'(obs[i].done), 32'(m_exp[i].done));
            chk("frame_abort", i, 32'(obs[i].ab),   32'(m_exp[i].ab));
            done_cnt[i]  += int'(obs[i].done);
            abort_cnt[i] += int'(obs[i].ab);
        end
        if (obs[0].done) dq.push_back(t);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 1'($urandom), 3'($urandom));
    endtask

    // Sync cycle then stream so that a receiver with offset fa sees img as
    // samples 0..63; the fa-1 leading cycles carry fill. Ends on that
    // receiver's commit cycle.
    task automatic frame(input logic [63:0] img, input int fa, input logic fill);
        step(1'b1, fill, 3'($urandom));
        for (int j = 1; j <= fa + 63; j++) begin
            int k;
            k = j - fa;
            step(1'b0, (k >= 0) ? img[k] : fill, 3'($urandom));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_rd_row",  i, 32'(obs[i].rd),   32'h00);
            chk("rst_row_sel", i, 32'(obs[i].rs),   32'h01);
            chk("rst_col",     i, 32'(obs[i].col),  32'h00);
            chk("rst_count",   i, 32'(obs[i].cnt),  32'h00);
            chk("rst_done",    i, 32'(obs[i].done), 32'h0);
            chk("rst_abort",   i, 32'(obs[i].ab),   32'h0);
        end
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [63:0] cb;
        int s0;

        // Lit where x and y share parity: rows read 55, AA, 55, ...
        for (int k = 0; k < 64; k++) cb[k] = ~(k[0] ^ k[3]);
        for (int y = 0; y < 8; y++) rb_tab[y] = '{3'(y), (y % 2 == 0) ? 8'h55 : 8'hAA};
        for (int c = 0; c < 40; c++) sc_tab[c] = '{c, 8'(1 << ((c / RD0) % 8))};

        bus0.frame_sync = 1'b0; bus1.frame_sync = 1'b0;
        bus0.pixel_data = '0;   bus1.pixel_data = '0;
        bus0.rd_y = '0;         bus1.rd_y = '0;
        for (int i = 0; i < 2; i++) begin done_cnt[i] = 0; abort_cnt[i] = 0; end

        @(posedge clk);
        #1;
        do_reset();

        // Scanner with REFRESH_DIV=4: one-hot row steps every 4 cycles.
        for (int c = 0; c < 40; c++) begin
            if (c > 0) idle(1);
            chk("scan_row_sel", 0, 32'(obs[0].rs), 32'(sc_tab[c].exp_sel));
        end

        // Single checkerboard frame, commit placed mid-row on dut0.
        while ((t + 66) % RD0 != 2) idle(1);
        s0 = t;
        frame(cb, 1, 1'b0);
        chk("done_before", 0, 32'(obs[0].done), 32'h0);
        idle(1);
        chk("done_at_S66", 0, 32'(t - s0), 32'd66);
        chk("done_pulse",  0, 32'(obs[0].done), 32'h1);
        chk("col_no_tear", 0, 32'(obs[0].col), 32'h00);
        while (t % RD0 != 0) idle(1);
        chk("col_boundary", 0, 32'(obs[0].col), ((t / RD0) % 2 == 0) ? 32'h55 : 32'hAA);
        idle(3);
        for (int v = 0; v < 8; v++) begin
            step(1'b0, 1'b0, rb_tab[v].rd_y);
            chk("cb_readback", 0, 32'(obs[0].rd), 32'(rb_tab[v].exp_row));
        end

        // Abort at sample 30, then a full all-ones frame.
        for (int i = 0; i < 2; i++) begin done_cnt[i] = 0; abort_cnt[i] = 0; end
        step(1'b1, 1'b0, 3'd0);
        for (int j = 0; j < 30; j++) step(1'b0, 1'($urandom), 3'($urandom));
        frame('1, F1, 1'b1);
        idle(1);
        for (int y = 0; y < 8; y++) begin
            step(1'b0, 1'b0, 3'(y));
            chk("abort_rd_ones0", 0, 32'(obs[0].rd), 32'hFF);
            chk("abort_rd_ones1", 1, 32'(obs[1].rd), 32'hFF);
        end
        for (int i = 0; i < 2; i++) begin
            chk("abort_pulses", i, 32'(abort_cnt[i]), 32'd1);
            chk("abort_dones",  i, 32'(done_cnt[i]),  32'd1);
            chk("abort_count",  i, 32'(obs[i].cnt),   32'd2);
        end

        // Back-to-back on dut0: second sync on the commit cycle.
        dq.delete();
        frame('1, F0, 1'b1);
        frame('0, F0, 1'b0);
        idle(4);
        chk("b2b_pulses", 0, 32'(dq.size()), 32'd2);
        if (dq.size() == 2) chk("b2b_spacing", 0, 32'(dq[1] - dq[0]), 32'd65);
        for (int y = 0; y < 8; y++) begin
            step(1'b0, 1'b0, 3'(y));
            chk("b2b_rd_zero", 0, 32'(obs[0].rd), 32'h00);
        end

        // Reset in the middle of a capture, then a normal frame.
        step(1'b1, 1'b1, 3'd0);
        idle(20);
        do_reset();
        frame({$urandom, $urandom}, F1, 1'($urandom));
        idle(4);
        for (int i = 0; i < 2; i++) chk("post_rst_count", i, 32'(obs[i].cnt), 32'd1);

        // Random sync spacing: back-to-back, aborts and idle gaps.
        for (int n = 0; n < 40; n++) begin
            int gap;
            case ($urandom_range(0, 3))
                0:       gap = 65;
                1:       gap = 67;
                2:       gap = $urandom_range(2, 64);
                default: gap = $urandom_range(68, 110);
            endcase
            step(1'b1, 1'($urandom), 3'($urandom));
            idle(gap - 1);
        end
        idle(80);

        // 256 marker frames at F=3 spacing: counter wraps to 0.
        do_reset();
        for (int i = 0; i < 2; i++) done_cnt[i] = 0;
        for (int n = 0; n < 256; n++) frame(64'h1, F1, 1'b0);
        idle(3);
        for (int i = 0; i < 2; i++) begin
            chk("wrap_count", i, 32'(obs[i].cnt),  32'd0);
            chk("wrap_dones", i, 32'(done_cnt[i]), 32'd256);
        end
        step(1'b0, 1'b0, 3'd0);
        chk("marker_row0_f3", 1, 32'(obs[1].rd), 32'h01);
        chk("marker_row0_f1", 0, 32'(obs[0].rd), 32'h04);
        step(1'b0, 1'b0, 3'd1);
        chk("marker_row1_f3", 1, 32'(obs[1].rd), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
